// File: rtl/bnn_dot_seq_ctrl.sv
// bnn_dot_seq_ctrl: issues one chunk address per cycle and accumulates the returned adder-tree sums.
// Latency: start accepted in cycle 0, reads in cycles 1..N, res_valid from cycle N+2 (cycle 1 when N=0).
// Backpressure: the result is held in DONE until res_ready; start is ignored while busy.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, base_addr,        begin an operation (IDLE only); first chunk address
//   num_chunks               and chunk count are latched on an accepted start
//   busy                     high in any state other than IDLE
//   mem_rd_en, mem_addr      registered buffer read strobe and chunk address
//   tree_sum                 unsigned adder-tree sum, valid one cycle after mem_rd_en
//   res_valid, res_ready     result handshake to the downstream stage
//   result, overflow         accumulated dot product, sticky saturation flag
module bnn_dot_seq_ctrl #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11,
  parameter int SUM_W  = 21,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_chunks,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [SUM_W-1:0]  tree_sum,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow
);

  localparam int PAD_W = ACC_W + 1 - SUM_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    n_q, n_d;
  // Number of reads issued so far in this operation.
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  // Marks the cycle in which tree_sum carries the answer to last cycle's read.
  logic                rd_pending_q, rd_pending_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [ACC_W-1:0]    result_q, result_d;

  // One extra bit catches the carry out of the accumulator.
  logic [ACC_W:0]      sum_ext;

  assign sum_ext = {1'b0, acc_q} + {{PAD_W{1'b0}}, tree_sum};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      rd_pending_q <= 1'b0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      rd_pending_q <= rd_pending_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      result_q     <= result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    n_d          = n_q;
    idx_d        = idx_q;
    rd_en_d      = 1'b0;
    addr_d       = addr_q;
    rd_pending_d = rd_en_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    result_d     = result_q;

    // Accumulate the sum for the read issued last cycle; saturate on carry.
    // A saturated accumulator stays saturated since any further add either
    // carries again or adds zero.
    if (rd_pending_q) begin
      if (sum_ext[ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum_ext[ACC_W-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d  = '0;
          ovf_d  = 1'b0;
          base_d = base_addr;
          n_d    = num_chunks;
          if (num_chunks != '0) begin
            // First read goes out registered in cycle 1.
            rd_en_d = 1'b1;
            addr_d  = base_addr;
            idx_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = ISSUE;
          end else begin
            result_d = '0;
            state_d  = DONE;
          end
        end
      end

      ISSUE: begin
        if (idx_q == n_q) begin
          state_d = DRAIN;
        end else begin
          rd_en_d = 1'b1;
          // Address arithmetic wraps naturally at ADDR_W bits.
          addr_d  = base_q + idx_q[ADDR_W-1:0];
          idx_d   = idx_q + 1'b1;
        end
      end

      DRAIN: begin
        // acc_d already includes the last pending sum.
        result_d = acc_d;
        idx_d    = '0;
        state_d  = DONE;
      end

      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign result    = result_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bnn_dot_seq_ctrl.sv
module tb_bnn_dot_seq_ctrl;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 11;
  localparam int SUM_W  = 21;
  localparam int ACC_W  = 22;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_chunks;
  logic              busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [SUM_W-1:0]  tree_sum;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  result;
  logic              overflow;

  int n_checks = 0;
  int n_err    = 0;

  logic [SUM_W-1:0] sums [0:15];
  int               rd_idx;

  bnn_dot_seq_ctrl #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W),
    .SUM_W (SUM_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_chunks(num_chunks),
    .busy      (busy),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .tree_sum  (tree_sum),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer + adder-tree stand-in: answers each read one cycle later with the
  // next entry of sums[]; drives a junk value when no answer is due.
  always @(posedge clk) begin
    if (start && !busy && !rst) begin
      rd_idx <= 0;
    end else if (mem_rd_en) begin
      rd_idx <= rd_idx + 1;
    end
    if (mem_rd_en && rd_idx < 16) tree_sum <= sums[rd_idx];
    else                          tree_sum <= 21'h0ABCD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one operation: checks read timing/addresses, latency, result, then
  // holds res_ready low for 'hold' cycles (optionally poking start) and
  // completes the handshake.
  task automatic do_op(input logic [ADDR_W-1:0] b, input int n,
                       input logic [31:0] exp_res, input logic exp_ovf,
                       input int hold, input bit poke);
    int k;
    int nrd;
    @(negedge clk);
    start      = 1'b1;
    base_addr  = b;
    num_chunks = n[CNT_W-1:0];
    @(negedge clk);
    start = 1'b0;
    k   = 1;
    nrd = 0;
    while (!res_valid && k < 200) begin
      if (mem_rd_en) begin
        chk("rd_cycle", k, nrd + 1);
        chk("rd_addr", {22'd0, mem_addr}, (b + nrd) % 1024);
        nrd++;
      end
      @(negedge clk);
      k++;
    end
    chk("latency", k, (n == 0) ? 1 : n + 2);
    chk("num_reads", nrd, n);
    chk("result", {10'd0, result}, exp_res);
    chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    chk("busy_done", {31'd0, busy}, 1);
    for (int i = 0; i < hold; i++) begin
      start = poke && (i == 1);
      if (poke && i == 1) begin
        base_addr  = 10'd100;
        num_chunks = 11'd3;
      end
      @(negedge clk);
      start = 1'b0;
      chk("hold_valid", {31'd0, res_valid}, 1);
      chk("hold_result", {10'd0, result}, exp_res);
      chk("hold_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
      chk("hold_busy", {31'd0, busy}, 1);
      chk("hold_rd_en", {31'd0, mem_rd_en}, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("post_valid", {31'd0, res_valid}, 0);
    chk("post_busy", {31'd0, busy}, 0);
    chk("post_rd_en", {31'd0, mem_rd_en}, 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    num_chunks = '0;
    res_ready  = 1'b0;
    for (int i = 0; i < 16; i++) sums[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 0);
    chk("rst_addr", {22'd0, mem_addr}, 0);
    chk("rst_valid", {31'd0, res_valid}, 0);
    chk("rst_result", {10'd0, result}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic run: 1+2+3+4.
    sums[0] = 21'd1; sums[1] = 21'd2; sums[2] = 21'd3; sums[3] = 21'd4;
    do_op(10'd0, 4, 32'd10, 1'b0, 0, 1'b0);

    // Zero-length run, busy held until handshake.
    do_op(10'd5, 0, 32'd0, 1'b0, 2, 1'b0);

    // Address wrap.
    sums[0] = 21'd100; sums[1] = 21'd2000; sums[2] = 21'd30000; sums[3] = 21'd1048575;
    do_op(10'd1022, 4, 32'd1080675, 1'b0, 0, 1'b0);

    // Saturation at ACC_W=22, then overflow cleared by the next start.
    sums[0] = 21'd2097151; sums[1] = 21'd2097151; sums[2] = 21'd2097151;
    do_op(10'd0, 3, 32'd4194303, 1'b1, 0, 1'b0);
    sums[0] = 21'd5;
    do_op(10'd0, 1, 32'd5, 1'b0, 0, 1'b0);

    // Backpressure with an ignored start pulse.
    sums[0] = 21'd11; sums[1] = 21'd22;
    do_op(10'd7, 2, 32'd33, 1'b0, 5, 1'b1);

    // Reset in cycle 2 of an N=8 run.
    for (int i = 0; i < 8; i++) sums[i] = 21'd1000;
    @(negedge clk);
    start      = 1'b1;
    base_addr  = 10'd0;
    num_chunks = 11'd8;
    @(negedge clk);
    start = 1'b0;
    chk("abort_rd_c1", {31'd0, mem_rd_en}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_rd_en", {31'd0, mem_rd_en}, 0);
    chk("abort_addr", {22'd0, mem_addr}, 0);
    chk("abort_valid", {31'd0, res_valid}, 0);
    chk("abort_result", {10'd0, result}, 0);
    chk("abort_ovf", {31'd0, overflow}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_idle_busy", {31'd0, busy}, 0);
    chk("abort_idle_rd", {31'd0, mem_rd_en}, 0);
    sums[0] = 21'd7; sums[1] = 21'd9;
    do_op(10'd0, 2, 32'd16, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
